// File: rtl/ro_measure_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package ro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        CAPTURE,
        DONE
    } ro_state_t;

    localparam int unsigned RO_CNT_W = 16;
    localparam logic [RO_CNT_W-1:0] RO_SAT_VAL = 16'hFFFF;

    function automatic int unsigned ro_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold a phase length minus one (the timer load value).
    function automatic int unsigned ro_bits(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/ro_measure_ctrl_if.sv
// Result handshake between the measurement controller and its consumer.
interface ro_measure_ctrl_if import ro_pkg::*; ();

    logic [RO_CNT_W-1:0] result;
    logic                sat;
    logic                valid;
    logic                ready;

    modport master (output result, output sat, output valid, input ready);
    modport slave  (input result, input sat, input valid, output ready);

endinterface

// File: rtl/ro_measure_ctrl_phase_timer.sv
// Loadable down-counter shared by the CLEAR, GATE and SETTLE phases.
module ro_phase_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         armed;

    // Loaded with length-1 so done fires in the last cycle of the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = armed && (cnt == '0);

endmodule

// File: rtl/ro_measure_ctrl.sv
// Gates the external Counter, captures settled counts and averages
// 2^AVG_LOG2 samples into one result delivered over a valid/ready handshake.
module ro_measure_ctrl import ro_pkg::*; #(
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [RO_CNT_W-1:0] cnt_in,
    output logic                cnt_reset,
    output logic                cnt_enable,
    output logic                busy,
    ro_measure_ctrl_if.master   res
);

    localparam int unsigned TW    = ro_bits(ro_max3(CLR_CYCLES, GATE_CYCLES, SETTLE_CYCLES));
    localparam int unsigned ACC_W = RO_CNT_W + AVG_LOG2;
    localparam int unsigned IDX_W = AVG_LOG2 + 1;

    localparam logic [TW-1:0]    CLR_LD    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((1 << AVG_LOG2) - 1);

    ro_state_t         state_q, state_d;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_done;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_sum;
    logic [IDX_W-1:0]  idx_q;
    logic              sat_q;
    logic              sample_sat;
    logic              last_sample;

    ro_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        acc_sum     = acc_q + ACC_W'(cnt_in);
        sample_sat  = (cnt_in == RO_SAT_VAL);
        last_sample = (idx_q == LAST_IDX);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LD;
                end
            end
            CLEAR: begin
                if (tmr_done) begin
                    state_d  = GATE;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LD;
                end
            end
            GATE: begin
                if (tmr_done) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (tmr_done) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (last_sample) begin
                    state_d = DONE;
                end else begin
                    state_d  = CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LD;
                end
            end
            DONE: begin
                if (res.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            idx_q      <= '0;
            sat_q      <= 1'b0;
            cnt_reset  <= 1'b0;
            cnt_enable <= 1'b0;
            busy       <= 1'b0;
            res.valid  <= 1'b0;
            res.result <= '0;
            res.sat    <= 1'b0;
        end else begin
            cnt_reset  <= (state_d == CLEAR);
            cnt_enable <= (state_d == GATE);
            busy       <= (state_d != IDLE);
            res.valid  <= (state_d == DONE);

            if (state_q == IDLE && start) begin
                acc_q <= '0;
                idx_q <= '0;
                sat_q <= 1'b0;
            end

            if (state_q == CAPTURE) begin
                acc_q <= acc_sum;
                idx_q <= idx_q + 1'b1;
                sat_q <= sat_q | sample_sat;
                if (last_sample) begin
                    res.result <= acc_sum[AVG_LOG2 +: RO_CNT_W];
                    res.sat    <= sat_q | sample_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Self-checking bench: timing vectors on a single-sample instance and a
// Counter-model-driven averaging instance checked against a reference model.
module tb_ro_measure_ctrl;
    import ro_pkg::*;

    localparam int unsigned C  = 2;
    localparam int unsigned G  = 10;
    localparam int unsigned S  = 3;
    localparam int unsigned P  = C + G + S + 1;
    localparam int unsigned N1 = 4;

    logic clk = 1'b0;
    logic reset;

    logic        start0, cr0, ce0, busy0;
    logic [15:0] cnt0;
    ro_measure_ctrl_if rif0 ();

    logic        start1, cr1, ce1, busy1;
    logic [15:0] cnt1 = '0;
    ro_measure_ctrl_if rif1 ();

    ro_measure_ctrl #(.CLR_CYCLES(C), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .AVG_LOG2(0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .cnt_in(cnt0),
        .cnt_reset(cr0), .cnt_enable(ce0), .busy(busy0), .res(rif0)
    );

    ro_measure_ctrl #(.CLR_CYCLES(C), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .AVG_LOG2(2)) u1 (
        .clk(clk), .reset(reset), .start(start1), .cnt_in(cnt1),
        .cnt_reset(cr1), .cnt_enable(ce1), .busy(busy1), .res(rif1)
    );

    always #5 clk = ~clk;

    // Counter model: runs during the gate, then freezes on the programmed sample.
    logic [15:0] samp1 [256];
    int unsigned win1 = 0;
    logic        en1_d = 1'b0;
    always @(posedge clk) begin
        en1_d <= ce1;
        if (cr1) begin
            cnt1 <= '0;
        end else if (ce1) begin
            cnt1 <= cnt1 + 16'd1;
        end else if (en1_d) begin
            cnt1 <= samp1[win1 % 256];
            win1 <= win1 + 1;
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] sample;
        logic [15:0] exp_res;
        logic        exp_sat;
        logic        start_at_hs;
    } vec_t;

    task automatic run0(input vec_t v);
        int unsigned k, rf, rl, ef, el, both;
        rf = 0; rl = 0; ef = 0; el = 0; both = 0;
        cnt0   = v.sample;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        chk("busy_rise", busy0, 1'b1);
        for (k = 1; k <= 100; k++) begin
            if (cr0) begin if (rf == 0) rf = k; rl = k; end
            if (ce0) begin if (ef == 0) ef = k; el = k; end
            if (cr0 && ce0) both++;
            if (rif0.valid) break;
            tick;
        end
        chk("latency", k, P + 1);
        chk("clr_first", rf, 1);
        chk("clr_last", rl, C);
        chk("gate_first", ef, C + 1);
        chk("gate_last", el, C + G);
        chk("ctrl_overlap", both, 0);
        chk("result", rif0.result, v.exp_res);
        chk("sat", rif0.sat, v.exp_sat);
        rif0.ready = 1'b1;
        start0     = v.start_at_hs;
        tick;
        rif0.ready = 1'b0;
        start0     = 1'b0;
        chk("hs_valid_low", rif0.valid, 1'b0);
        chk("hs_busy_low", busy0, 1'b0);
        tick;
        chk("hs_start_ignored", busy0, 1'b0);
    endtask

    task automatic run1(input logic [63:0] smp);
        int unsigned base, sum, k, hold;
        logic        any_sat, bad;
        logic [15:0] v;
        base = win1; sum = 0; any_sat = 1'b0; bad = 1'b0;
        for (int i = 0; i < N1; i++) begin
            v = smp[16*i +: 16];
            samp1[(base + i) % 256] = v;
            sum += v;
            any_sat |= (v == RO_SAT_VAL);
        end
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (k = 1; k <= 400; k++) begin
            if (rif1.valid) break;
            tick;
        end
        chk("avg_latency", k, N1 * P + 1);
        chk("avg_result", rif1.result, sum / N1);
        chk("avg_sat", rif1.sat, any_sat);
        chk("avg_windows", win1 - base, N1);
        hold = $urandom_range(0, 6);
        repeat (hold) begin
            tick;
            if (rif1.result !== 16'(sum / N1) || rif1.valid !== 1'b1 || cr1 || ce1) bad = 1'b1;
        end
        chk("avg_hold", bad, 1'b0);
        rif1.ready = 1'b1;
        tick;
        rif1.ready = 1'b0;
        chk("avg_release", rif1.valid, 1'b0);
    endtask

    vec_t vt [5];

    initial begin
        int unsigned k, bad, vcnt, idle_between;
        int unsigned vt_at [4];
        logic [63:0] smp;
        logic [15:0] r;

        vt[0] = '{16'h1234, 16'h1234, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vt[2] = '{16'h0005, 16'h0005, 1'b0, 1'b0};
        vt[3] = '{16'hFFFE, 16'hFFFE, 1'b0, 1'b1};
        vt[4] = '{16'h0000, 16'h0000, 1'b0, 1'b1};

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; cnt0 = '0;
        rif0.ready = 1'b0; rif1.ready = 1'b0;
        tick; tick;
        chk("rst_cnt_reset", cr0, 1'b0);
        chk("rst_cnt_enable", ce0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_valid", rif0.valid, 1'b0);
        chk("rst_result", rif0.result, 16'h0);
        chk("rst_sat", rif0.sat, 1'b0);
        chk("rst_valid1", rif1.valid, 1'b0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) run0(vt[i]);

        // Backpressure: result held, start ignored while DONE.
        cnt0 = 16'h00AB; start0 = 1'b1; tick; start0 = 1'b0;
        for (k = 1; k <= 100; k++) begin
            if (rif0.valid) break;
            tick;
        end
        chk("bp_latency", k, P + 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start0 = (i == 5);
            tick;
            if (rif0.result !== 16'h00AB || rif0.sat !== 1'b0 || rif0.valid !== 1'b1 || cr0 || ce0) bad++;
        end
        start0 = 1'b0;
        chk("bp_hold", bad, 0);
        rif0.ready = 1'b1; tick; rif0.ready = 1'b0;
        chk("bp_valid_low", rif0.valid, 1'b0);
        chk("bp_busy_low", busy0, 1'b0);
        bad = 0;
        repeat (5) begin tick; if (busy0 || cr0 || ce0) bad++; end
        chk("bp_no_queue", bad, 0);

        // Reset during the 5th GATE cycle.
        cnt0 = 16'h0077; start0 = 1'b1; tick; start0 = 1'b0;
        repeat (C + 4) tick;
        chk("gate5_on", ce0, 1'b1);
        reset = 1'b1; tick; reset = 1'b0;
        chk("mid_rst_enable", ce0, 1'b0);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_valid", rif0.valid, 1'b0);
        chk("mid_rst_clr", cr0, 1'b0);
        run0('{16'h0077, 16'h0077, 1'b0, 1'b0});

        // Back-to-back with start and ready held high.
        cnt0 = 16'h0042; rif0.ready = 1'b1; start0 = 1'b1;
        tick;
        vcnt = 0; idle_between = 0; bad = 0;
        for (int t = 1; t <= 60; t++) begin
            if (rif0.valid) begin
                if (vcnt < 4) vt_at[vcnt] = t;
                vcnt++;
                if (rif0.result !== 16'h0042) bad++;
            end
            if (!busy0 && vcnt == 1) idle_between++;
            tick;
        end
        start0 = 1'b0; rif0.ready = 1'b0;
        chk("b2b_count", (vcnt >= 2), 1'b1);
        chk("b2b_first", vt_at[0], P + 1);
        chk("b2b_period", vt_at[1] - vt_at[0], P + 2);
        chk("b2b_idle", idle_between, 1);
        chk("b2b_result", bad, 0);
        reset = 1'b1; tick; reset = 1'b0; tick;

        // Averaging instance against the reference model.
        run1({16'd103, 16'd102, 16'd101, 16'd100});
        run1({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        for (int rr = 0; rr < 6; rr++) begin
            for (int i = 0; i < N1; i++) begin
                r = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
                smp[16*i +: 16] = r;
            end
            run1(smp);
            repeat ($urandom_range(0, 3)) tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ro_measure_ctrl.md
# ro_measure_ctrl

Measurement controller for the ring-oscillator frequency counter. It sits directly downstream of the `Counter` block: it drives the counter's `reset` and `enable`, opens a gate window of a fixed number of system-clock cycles, and waits for the frozen count to settle. It then captures the 16-bit count and averages 2^AVG_LOG2 captures into one result. The result is delivered on a valid/ready handshake.

## Interface
Parameters:
- `CLR_CYCLES`, default 4: cycles `cnt_reset` is held high before each gate window (≥1).
- `GATE_CYCLES`, default 1000: cycles `cnt_enable` is held high per sample (≥1).
- `SETTLE_CYCLES`, default 4: cycles between gate close and capture; covers `cnt_in` crossing from the ring-osc domain (≥2).
- `AVG_LOG2`, default 2: log2 of the number of samples averaged (0..8).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: level-sampled request; accepted only in IDLE.
- `cnt_in` in 16: `out` of Counter.
- `cnt_reset` out 1: to Counter `reset`.
- `cnt_enable` out 1: to Counter `enable`.
- `busy` out 1: high in every state except IDLE.
- `result` out 16: averaged count, `acc >> AVG_LOG2`.
- `sat` out 1: at least one sample in this result equalled 16'hFFFF.
- `valid` out 1: result available.
- `ready` in 1: consumer accepts the result.

## Operation
- States: IDLE → CLEAR → GATE → SETTLE → CAPTURE → (CLEAR | DONE) → IDLE.
- IDLE: `start`=1 clears acc (16+AVG_LOG2 bits), the sample index, and the sticky sat, then moves to CLEAR.
- CLEAR: `cnt_reset`=1 for CLR_CYCLES, then GATE.
- GATE: `cnt_enable`=1 for GATE_CYCLES, then SETTLE.
- SETTLE: both counter controls are 0 for SETTLE_CYCLES, then CAPTURE.
- CAPTURE: one cycle.
  - acc += `cnt_in`, zero-extended.
  - sat_sticky |= (`cnt_in` == 16'hFFFF).
  - index++.
  - If index was 2^AVG_LOG2−1, go to DONE; otherwise go to CLEAR.
- DONE:
  - `result` = acc[AVG_LOG2 +: 16], truncating division; `sat` = sat_sticky; `valid`=1.
  - `result`/`sat` are held stable while `valid`=1 and `ready`=0.
  - `valid`&`ready` → IDLE.
- `start` outside IDLE is ignored; no queuing.
- acc cannot overflow: its width is 16+AVG_LOG2.

## Timing
- Reset values: `cnt_reset`=0, `cnt_enable`=0, `busy`=0, `valid`=0, `result`=0, `sat`=0, state IDLE. All outputs are registered.
- `start` is sampled high at edge n:
  - `busy` high from n+1.
  - `cnt_reset` high for cycles n+1 .. n+C, where C=CLR_CYCLES.
  - `cnt_enable` high for cycles n+C+1 .. n+C+G, where G=GATE_CYCLES.
  - Capture at cycle n+C+G+S+1, where S=SETTLE_CYCLES.
- Per-sample period P = C+G+S+1. `valid` rises at cycle n + 2^AVG_LOG2·P + 1.
- Handshake at edge m (`valid`&`ready`): `valid` and `busy` are 0 from m+1. A new `start` can be accepted at the earliest at edge m+1.
- `start` and `ready` high together in DONE: the handshake completes and `start` is ignored; `start` must be reasserted in IDLE.
- `reset` mid-operation: on the next cycle all outputs return to reset values and the counter gate closes. The partial accumulation is discarded.
- `cnt_reset` and `cnt_enable` are never high in the same cycle.

## Structure
- Package `ro_pkg`:
  - state enum `ro_state_t` (IDLE, CLEAR, GATE, SETTLE, CAPTURE, DONE);
  - `RO_CNT_W`=16;
  - `RO_SAT_VAL`=16'hFFFF.
- Sub-module `ro_phase_timer`:
  - a loadable down-counter sized to max(C,G,S);
  - loaded on each phase entry, with a `done` pulse when it reaches zero;
  - the FSM uses a single instance shared across phases.

## Test plan
- C=2, G=10, S=3, AVG_LOG2=0, `cnt_in`=16'h1234, `start` at edge 0:
  - `cnt_reset` high cycles 1–2;
  - `cnt_enable` high cycles 3–12;
  - `valid` rises cycle 17 with `result`=16'h1234, `sat`=0.
- AVG_LOG2=2, bench model of Counter on a fast clock yielding captures 100, 101, 102, 103 → acc=406, `result`=101, exactly 4 gate windows observed.
- A sample equal to 16'hFFFF (AVG_LOG2=0) → `result`=16'hFFFF, `sat`=1. The next run with `cnt_in`=5 gives `sat`=0.
- Backpressure: hold `ready`=0 for 20 cycles after `valid` and pulse `start` meanwhile → `result` stable, no new gate window. `ready`=1 → `valid`=0 next cycle, `busy`=0.
- `reset` asserted during the 5th GATE cycle → next cycle `cnt_enable`=0, `busy`=0, `valid`=0. A fresh `start` then produces the full C+G+S+2 latency.
- `start` held high continuously with `ready`=1 → back-to-back measurements, each separated by exactly one IDLE cycle.
